multicycle_core_seq: RTL
========================

Name: multicycle_core_seq

Overview:
- Sequencer for the next-generation RV core. It replaces single-cycle, one-instruction-per-clock execution with a multi-cycle FSM.
- It owns the PC and the latched instruction register.
- It talks to instruction and data memory over valid/ready handshakes.
- It gates register-file writes to exactly one pulse per retired instruction, and keeps cycle and retire counters.
- Decode, ALU, immediate and branch logic stay combinational outside this block. They feed it the decoded controls each instruction.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles to wait on any memory response before entering ERROR; 0 disables the timeout.
- CNT_W, 64, width of the cycle and retire counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  instruction memory accepts request.
- imem_addr  out  XLEN  fetch address (equals pc).
- imem_rsp_valid  in  1  instruction word valid.
- imem_rsp_data  in  32  instruction word.
- inst  out  32  latched instruction, stable from EXEC through WB.
- pc  out  XLEN  current PC.
- dec_load  in  1  decoded load.
- dec_store  in  1  decoded store.
- dec_w_en  in  1  decoded register write.
- dec_ebreak  in  1  decoded ebreak.
- jump_en  in  1  jal/jalr/taken-branch.
- jump_pc  in  XLEN  jump target (ALU output).
- dmem_req_valid  out  1  data request.
- dmem_req_ready  in  1  data memory accepts request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_rsp_valid  in  1  load data valid, or store acknowledge.
- rf_w_en  out  1  register-file write strobe, one cycle per instruction.
- retire  out  1  one-cycle pulse when an instruction commits.
- halted  out  1  ebreak reached.
- error  out  1  timeout or misaligned target.
- cycle_cnt  out  CNT_W  cycles since reset.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- States: FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERROR.
- Reset, effective on the clk edge:
  - state = FETCH_REQ, pc = RESET_PC, inst = 32'h0000_0013 (nop).
  - All strobes 0, halted = 0, error = 0, both counters = 0, wait counter = 0.
  - Reset asserted in any state, including mid-handshake, aborts the instruction with no write and no retire.
  - The memories must drop any outstanding response after reset.
- FETCH_REQ:
  - imem_req_valid = 1.
  - On imem_req_ready, go to FETCH_WAIT.
  - imem_addr is held stable while valid is high without ready.
- FETCH_WAIT:
  - On imem_rsp_valid, latch imem_rsp_data into inst and go to EXEC.
  - A response arriving in the same cycle as the handshake is not accepted; the response must come at least 1 cycle after acceptance.
- EXEC: one cycle for the decode/ALU to settle on the new inst.
  - dec_ebreak → HALT.
  - Otherwise dec_load or dec_store → MEM_REQ.
  - Otherwise → WB.
- MEM_REQ:
  - dmem_req_valid = 1 and dmem_we = dec_store.
  - On dmem_req_ready, go to MEM_WAIT.
- MEM_WAIT: on dmem_rsp_valid, go to WB.
- WB, exactly one cycle:
  - rf_w_en = dec_w_en.
  - retire = 1.
  - instret_cnt increments.
  - pc updates to jump_pc if jump_en, else pc+4, wrapping modulo 2^XLEN.
  - Next state is FETCH_REQ.
  - If jump_en and jump_pc[1:0] != 0: go to ERROR instead. No rf write, no retire, pc unchanged.
- Wait counter:
  - Resets on entry to any of the four memory states and counts each cycle spent in them.
  - If it reaches TIMEOUT (nonzero), go to ERROR.
- HALT: halted = 1, terminal until reset. retire pulses once on entry; instret_cnt counts the ebreak.
- ERROR: error = 1, terminal until reset. No strobes.
- cycle_cnt increments every non-reset cycle, including in HALT and ERROR. Both counters wrap at 2^CNT_W.
- Minimum latency:
  - ALU instruction: 4 cycles (FETCH_REQ, FETCH_WAIT, EXEC, WB) with zero-wait memory.
  - Load/store: 6 cycles.
- All outputs are registered or derived from state only. No combinational path from any input to any *_req_valid.

Test Plan:
- Reset then addi stream, single-cycle-ready imem responding 1 cycle later → pc steps 8000_0000, 8000_0004, …; retire every 4 cycles; rf_w_en = 1 exactly in WB; instret_cnt = 10 after 10 instructions.
- jal with jump_pc = 8000_0100 → next imem_addr = 8000_0100. Branch with jump_en = 0 → pc+4. jump_pc = 8000_0102 → error = 1, retire = 0, pc unchanged.
- Load with dmem_req_ready delayed 3 cycles and rsp delayed 5 cycles → req_valid held high 4 cycles; rf_w_en single pulse; retire after 4+3+5+2 cycles. Store → dmem_we = 1, rf_w_en = 0.
- imem never responds, TIMEOUT = 255 → error = 1 after 255 cycles in FETCH_WAIT. TIMEOUT = 0 → waits forever, no error.
- Reset asserted in MEM_WAIT → next cycle pc = 8000_0000, counters = 0, no rf_w_en, no retire. A stale dmem_rsp_valid arriving in FETCH_REQ is ignored.
- ebreak after 5 instructions → halted = 1, instret_cnt = 6, imem_req_valid stays 0, cycle_cnt keeps counting.

Source files
------------

// File: rtl/multicycle_core_seq.sv
// Multi-cycle instruction sequencer: owns the PC and instruction register,
// drives the instruction/data memory handshakes, gates register-file writes
// to one strobe per retired instruction, and keeps cycle/retire counters.
module multicycle_core_seq #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = 32'h8000_0000,
  parameter int unsigned          TIMEOUT  = 255,
  parameter int unsigned          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  pc,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_w_en,
  input  logic             dec_ebreak,
  input  logic             jump_en,
  input  logic [XLEN-1:0]  jump_pc,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  input  logic             dmem_rsp_valid,
  output logic             rf_w_en,
  output logic             retire,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              storeOp_q, storeOp_d;
  logic              wrEn_q, wrEn_d;
  logic              jumpEn_q, jumpEn_d;
  logic [XLEN-1:0]   jumpTgt_q, jumpTgt_d;
  logic              haltEntry_q, haltEntry_d;
  logic [31:0]       waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0]  cycleCnt_q, instretCnt_q;

  logic inMemState;
  logic timeoutHit;
  logic misaligned;
  logic wbCommit;
  logic retireNow;

  // Decoded controls are captured in EXEC so every strobe below depends only on registers.
  assign inMemState = (state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) ||
                      (state_q == S_MEM_REQ)   || (state_q == S_MEM_WAIT);
  assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q >= TIMEOUT_LAST);
  assign misaligned = jumpEn_q && (jumpTgt_q[1:0] != 2'b00);
  assign wbCommit   = (state_q == S_WB) && !misaligned;
  assign retireNow  = wbCommit || haltEntry_q;

  assign imem_req_valid = (state_q == S_FETCH_REQ);
  assign imem_addr      = pc_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign dmem_req_valid = (state_q == S_MEM_REQ);
  assign dmem_we        = (state_q == S_MEM_REQ) && storeOp_q;
  assign rf_w_en        = wbCommit && wrEn_q;
  assign retire         = retireNow;
  assign halted         = (state_q == S_HALT);
  assign error          = (state_q == S_ERROR);
  assign cycle_cnt      = cycleCnt_q;
  assign instret_cnt    = instretCnt_q;

  // Next-state logic: sequence each instruction through fetch, execute, memory and writeback.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    storeOp_d   = storeOp_q;
    wrEn_d      = wrEn_q;
    jumpEn_d    = jumpEn_q;
    jumpTgt_d   = jumpTgt_q;
    haltEntry_d = 1'b0;
    waitCnt_d   = waitCnt_q;

    case (state_q)
      S_FETCH_REQ: begin
        if (imem_req_ready) state_d = S_FETCH_WAIT;
        else if (timeoutHit) state_d = S_ERROR;
      end
      S_FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_EXEC;
        end else if (timeoutHit) begin
          state_d = S_ERROR;
        end
      end
      S_EXEC: begin
        if (dec_ebreak) begin
          state_d     = S_HALT;
          haltEntry_d = 1'b1;
        end else begin
          storeOp_d = dec_store;
          wrEn_d    = dec_w_en;
          jumpEn_d  = jump_en;
          jumpTgt_d = jump_pc;
          state_d   = (dec_load || dec_store) ? S_MEM_REQ : S_WB;
        end
      end
      S_MEM_REQ: begin
        if (dmem_req_ready) state_d = S_MEM_WAIT;
        else if (timeoutHit) state_d = S_ERROR;
      end
      S_MEM_WAIT: begin
        if (dmem_rsp_valid) state_d = S_WB;
        else if (timeoutHit) state_d = S_ERROR;
      end
      S_WB: begin
        if (misaligned) begin
          state_d = S_ERROR;
        end else begin
          pc_d    = jumpEn_q ? jumpTgt_q : pc_q + XLEN'(4);
          state_d = S_FETCH_REQ;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase

    if (state_d != state_q) waitCnt_d = 32'd0;
    else if (inMemState)    waitCnt_d = waitCnt_q + 32'd1;
  end

  // State, instruction, PC and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      storeOp_q    <= 1'b0;
      wrEn_q       <= 1'b0;
      jumpEn_q     <= 1'b0;
      jumpTgt_q    <= '0;
      haltEntry_q  <= 1'b0;
      waitCnt_q    <= 32'd0;
      cycleCnt_q   <= '0;
      instretCnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      storeOp_q    <= storeOp_d;
      wrEn_q       <= wrEn_d;
      jumpEn_q     <= jumpEn_d;
      jumpTgt_q    <= jumpTgt_d;
      haltEntry_q  <= haltEntry_d;
      waitCnt_q    <= waitCnt_d;
      cycleCnt_q   <= cycleCnt_q + CNT_W'(1);
      if (retireNow) instretCnt_q <= instretCnt_q + CNT_W'(1);
    end
  end

endmodule
